// File: rtl/rr_mux_arbiter_if.sv
// Requester and consumer signal bundle for rr_mux_arbiter.
// The req_last lane exists only when RR_MUX_ARB_LOCK_EN is defined.
interface rr_mux_arbiter_if #(
  parameter int N = 4,
  parameter int W = 8
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ready;
`ifdef RR_MUX_ARB_LOCK_EN
  logic [N-1:0]   req_last;
`endif
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic           out_ready;
  logic [IW-1:0]  grant_id;

`ifdef RR_MUX_ARB_LOCK_EN
  modport slave (
    input  req_valid, req_data, req_last, out_ready,
    output req_ready, out_valid, out_data, grant_id
  );
  modport master (
    output req_valid, req_data, req_last, out_ready,
    input  req_ready, out_valid, out_data, grant_id
  );
`else
  modport slave (
    input  req_valid, req_data, out_ready,
    output req_ready, out_valid, out_data, grant_id
  );
  modport master (
    output req_valid, req_data, out_ready,
    input  req_ready, out_valid, out_data, grant_id
  );
`endif
endinterface

// File: rtl/rr_mux_arbiter.sv
// Round-robin N:1 arbiter with a single registered output stage.
// Define RR_MUX_ARB_LOCK_EN to hold the grant for multi-beat packets (req_last).
//
// state | meaning
// EMPTY | output register holds no beat
// FULL  | output register holds a beat awaiting out_ready
module rr_mux_arbiter #(
  parameter int N = 4,
  parameter int W = 8
) (
  input logic             clk,
  input logic             rst_n,
  rr_mux_arbiter_if.slave bus
);
  localparam int IW  = (N > 1) ? $clog2(N) : 1;
  localparam int IW1 = IW + 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  data_q, data_d;
  logic [IW-1:0] grant_q, grant_d;
  logic [IW-1:0] ptr_q, ptr_d;

  logic          scan_found;
  logic [IW-1:0] scan_winner;
  logic [IW1-1:0] idx;
  logic          found;
  logic [IW-1:0] winner;
  logic [IW-1:0] winner_inc;
  logic          can_load;
  logic          accept;
  logic [N-1:0]  ready;

`ifdef RR_MUX_ARB_LOCK_EN
  logic          lock_q, lock_d;
  logic [IW-1:0] lock_id_q, lock_id_d;
`endif

  // Ready is gated by rst_n so no requester sees a handshake during reset.
  assign can_load   = rst_n && ((state_q == EMPTY) || bus.out_ready);
  assign accept     = can_load && found;
  assign winner_inc = (winner == LAST_IDX) ? '0 : winner + IW'(1);

  always_comb begin
    scan_found  = 1'b0;
    scan_winner = '0;
    idx         = '0;
    for (int i = 0; i < N; i++) begin
      idx = {1'b0, ptr_q} + IW1'(i);
      if (idx >= IW1'(N)) idx = idx - IW1'(N);
      if (!scan_found && bus.req_valid[idx[IW-1:0]]) begin
        scan_found  = 1'b1;
        scan_winner = idx[IW-1:0];
      end
    end
  end

  always_comb begin
    found  = scan_found;
    winner = scan_winner;
`ifdef RR_MUX_ARB_LOCK_EN
    if (lock_q) begin
      found  = bus.req_valid[lock_id_q];
      winner = lock_id_q;
    end
`endif
  end

  always_comb begin
    ready = '0;
    if (accept) ready[winner] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
`ifdef RR_MUX_ARB_LOCK_EN
    lock_d    = lock_q;
    lock_id_d = lock_id_q;
`endif
    if (can_load) begin
      if (found) begin
        state_d = FULL;
        data_d  = bus.req_data[int'(winner) * W +: W];
        grant_d = winner;
`ifdef RR_MUX_ARB_LOCK_EN
        if (bus.req_last[winner]) begin
          lock_d = 1'b0;
          ptr_d  = winner_inc;
        end else begin
          lock_d    = 1'b1;
          lock_id_d = winner;
        end
`else
        ptr_d = winner_inc;
`endif
      end else begin
        state_d = EMPTY;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      data_q  <= '0;
      grant_q <= '0;
      ptr_q   <= '0;
`ifdef RR_MUX_ARB_LOCK_EN
      lock_q    <= 1'b0;
      lock_id_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
`ifdef RR_MUX_ARB_LOCK_EN
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
`endif
    end
  end

  assign bus.req_ready = ready;
  assign bus.out_valid = (state_q == FULL);
  assign bus.out_data  = data_q;
  assign bus.grant_id  = grant_q;
endmodule
